// File: rtl/spi_mstr_arb.sv
// Round-robin arbiter sharing one SPI master between the A2D client (0) and the
// inertial-sensor client (1), with a timed lock for back-to-back transactions.
module spi_mstr_arb #(
    parameter int HOLD_MAX = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req0_i,
    input  logic        req1_i,
    input  logic [15:0] cmd0_i,
    input  logic [15:0] cmd1_i,
    input  logic        lock0_i,
    input  logic        lock1_i,
    input  logic        done_i,
    output logic        wrt_o,
    output logic [15:0] cmd_o,
    output logic        ack0_o,
    output logic        ack1_o,
    output logic        done0_o,
    output logic        done1_o,
    output logic [1:0]  gnt_o,
    output logic        busy_o,
    output logic        lock_to_o
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUSY,
        HOLD
    } state_e;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    state_e      state_q;
    logic [15:0] cmd_q;
    logic [1:0]  gnt_q;
    logic        last_q;
    logic [7:0]  hold_cnt_q;
    logic        lock_to_q;

    logic [1:0]  win_d;
    logic [15:0] win_cmd_d;
    logic        owner_req;
    logic        owner_lock;
    logic [15:0] owner_cmd;

    // last_q = 1 means client 1 was served last, so client 0 wins the next tie.
    always_comb begin
        win_d = 2'b00;
        if (req0_i && req1_i) begin
            win_d = last_q ? 2'b01 : 2'b10;
        end else if (req0_i) begin
            win_d = 2'b01;
        end else if (req1_i) begin
            win_d = 2'b10;
        end
        win_cmd_d  = win_d[1] ? cmd1_i : cmd0_i;
        owner_req  = |(gnt_q & {req1_i, req0_i});
        owner_lock = |(gnt_q & {lock1_i, lock0_i});
        owner_cmd  = gnt_q[1] ? cmd1_i : cmd0_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cmd_q      <= 16'h0000;
            gnt_q      <= 2'b00;
            last_q     <= 1'b1;
            hold_cnt_q <= 8'd0;
            lock_to_q  <= 1'b0;
        end else begin
            lock_to_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_d != 2'b00) begin
                        gnt_q   <= win_d;
                        cmd_q   <= win_cmd_d;
                        last_q  <= win_d[1];
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= BUSY;
                end
                BUSY: begin
                    if (done_i) begin
                        if (owner_lock) begin
                            hold_cnt_q <= 8'd0;
                            state_q    <= HOLD;
                        end else begin
                            gnt_q   <= 2'b00;
                            state_q <= IDLE;
                        end
                    end
                end
                HOLD: begin
                    // Only the owner may re-request; the other client waits for IDLE.
                    if (owner_req) begin
                        cmd_q   <= owner_cmd;
                        state_q <= ISSUE;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        lock_to_q <= 1'b1;
                        gnt_q     <= 2'b00;
                        state_q   <= IDLE;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign wrt_o     = (state_q == ISSUE);
    assign ack0_o    = (state_q == ISSUE) & gnt_q[0];
    assign ack1_o    = (state_q == ISSUE) & gnt_q[1];
    assign done0_o   = (state_q == BUSY) & done_i & gnt_q[0];
    assign done1_o   = (state_q == BUSY) & done_i & gnt_q[1];
    assign cmd_o     = cmd_q;
    assign gnt_o     = gnt_q;
    assign busy_o    = (state_q != IDLE);
    assign lock_to_o = lock_to_q;

endmodule

// File: tb/tb_spi_mstr_arb.sv
// Directed bench for spi_mstr_arb: expected grants/commands are queued when a
// request is driven and popped when the arbiter issues wrt.
module tb_spi_mstr_arb;

    typedef struct packed {
        logic [1:0]  gnt;
        logic [15:0] cmd;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        req0, req1;
    logic [15:0] cmd0, cmd1;
    logic        lock0, lock1;
    logic        done;
    logic        wrt;
    logic [15:0] cmd;
    logic        ack0, ack1;
    logic        done0, done1;
    logic [1:0]  gnt;
    logic        busy;
    logic        lock_to;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    spi_mstr_arb #(.HOLD_MAX(16)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req0_i    (req0),
        .req1_i    (req1),
        .cmd0_i    (cmd0),
        .cmd1_i    (cmd1),
        .lock0_i   (lock0),
        .lock1_i   (lock1),
        .done_i    (done),
        .wrt_o     (wrt),
        .cmd_o     (cmd),
        .ack0_o    (ack0),
        .ack1_o    (ack1),
        .done0_o   (done0),
        .done1_o   (done1),
        .gnt_o     (gnt),
        .busy_o    (busy),
        .lock_to_o (lock_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Wait (bounded) for wrt, then compare against the oldest queued expectation.
    task automatic expectIssue(input string tag, output int lat);
        exp_t e;
        lat = 0;
        do begin
            step();
            lat++;
        end while (!wrt && lat < 40);
        checkOutput({tag, " wrt"}, 32'(wrt), 32'd1);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL %s scoreboard: observed empty expected entry", tag);
        end else begin
            e = sb.pop_front();
            checkOutput({tag, " gnt"}, 32'(gnt), 32'(e.gnt));
            checkOutput({tag, " cmd"}, 32'(cmd), 32'(e.cmd));
            checkOutput({tag, " ack"}, 32'({ack1, ack0}), 32'(e.gnt));
        end
    endtask

    // Let the transaction run, pulse done with the given locks, check routing.
    task automatic applyStimulus(input string tag, input logic [1:0] owner,
                                 input logic lk0, input logic lk1, input int nWait);
        repeat (nWait) step();
        checkOutput({tag, " busy before done"}, 32'(busy), 32'd1);
        checkOutput({tag, " wrt quiet"}, 32'(wrt), 32'd0);
        lock0 = lk0;
        lock1 = lk1;
        done  = 1'b1;
        #1;
        checkOutput({tag, " done route"}, 32'({done1, done0}), 32'(owner));
        step();
        done  = 1'b0;
        lock0 = 1'b0;
        lock1 = 1'b0;
        if (lk0 || lk1) begin
            checkOutput({tag, " gnt kept"}, 32'(gnt), 32'(owner));
            checkOutput({tag, " busy in hold"}, 32'(busy), 32'd1);
        end else begin
            checkOutput({tag, " gnt cleared"}, 32'(gnt), 32'd0);
            checkOutput({tag, " busy cleared"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int lat;
        int cnt;
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        cmd0 = 16'h0; cmd1 = 16'h0;
        lock0 = 1'b0; lock1 = 1'b0;
        done = 1'b0;

        // Reset state
        repeat (2) step();
        checkOutput("reset outputs",
                    32'({wrt, ack0, ack1, done0, done1, busy, lock_to}), 32'd0);
        checkOutput("reset cmd", 32'(cmd), 32'd0);
        checkOutput("reset gnt", 32'(gnt), 32'd0);
        rst_n = 1'b1;
        step();

        // Single request, one-cycle latency
        req0 = 1'b1; cmd0 = 16'h2000;
        sb.push_back('{gnt: 2'b01, cmd: 16'h2000});
        expectIssue("single", lat);
        checkOutput("single latency", 32'(lat), 32'd1);
        req0 = 1'b0;
        step();
        checkOutput("single wrt one cycle", 32'(wrt), 32'd0);
        applyStimulus("single", 2'b01, 1'b0, 1'b0, 37);

        // Locked pair with client 1 pending
        req0 = 1'b1; cmd0 = 16'h2000;
        sb.push_back('{gnt: 2'b01, cmd: 16'h2000});
        expectIssue("lock first", lat);
        req0 = 1'b0;
        req1 = 1'b1; cmd1 = 16'hC000;
        applyStimulus("lock first", 2'b01, 1'b1, 1'b0, 5);
        req0 = 1'b1; cmd0 = 16'h2800;
        sb.push_back('{gnt: 2'b01, cmd: 16'h2800});
        expectIssue("lock second", lat);
        checkOutput("lock second latency", 32'(lat), 32'd1);
        req0 = 1'b0;
        applyStimulus("lock second", 2'b01, 1'b0, 1'b0, 5);
        sb.push_back('{gnt: 2'b10, cmd: 16'hC000});
        expectIssue("client1 after unlock", lat);
        checkOutput("client1 latency", 32'(lat), 32'd1);
        req1 = 1'b0;

        // Hold timeout: client 1 locks and never returns
        applyStimulus("timeout txn", 2'b10, 1'b0, 1'b1, 5);
        req0 = 1'b1; cmd0 = 16'hD000;
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!lock_to && cnt < 40);
        checkOutput("lock_to delay", 32'(cnt), 32'd16);
        checkOutput("lock_to gnt cleared", 32'(gnt), 32'd0);
        sb.push_back('{gnt: 2'b01, cmd: 16'hD000});
        expectIssue("after timeout", lat);
        checkOutput("after timeout latency", 32'(lat), 32'd1);
        checkOutput("lock_to single pulse", 32'(lock_to), 32'd0);
        req0 = 1'b0;
        applyStimulus("after timeout", 2'b01, 1'b0, 1'b0, 4);

        // Stray done in IDLE
        done = 1'b1;
        #1;
        checkOutput("stray done route", 32'({done1, done0}), 32'd0);
        step();
        done = 1'b0;
        checkOutput("stray done state", 32'({busy, wrt, gnt}), 32'd0);

        // Tie with client 0 served last goes to client 1, then reset mid-BUSY
        req0 = 1'b1; cmd0 = 16'hE000;
        req1 = 1'b1; cmd1 = 16'hF000;
        sb.push_back('{gnt: 2'b10, cmd: 16'hF000});
        expectIssue("tie after client0", lat);
        step();
        checkOutput("mid busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        done  = 1'b1;
        #1;
        checkOutput("async reset outputs",
                    32'({wrt, ack0, ack1, done0, done1, busy, lock_to}), 32'd0);
        checkOutput("async reset cmd/gnt", 32'({cmd, gnt}), 32'd0);
        step();
        done  = 1'b0;
        rst_n = 1'b1;

        // Round-robin from reset with both requests held
        sb.push_back('{gnt: 2'b01, cmd: 16'hE000});
        sb.push_back('{gnt: 2'b10, cmd: 16'hF000});
        sb.push_back('{gnt: 2'b01, cmd: 16'hE001});
        sb.push_back('{gnt: 2'b10, cmd: 16'hF001});
        for (int i = 0; i < 4; i++) begin
            expectIssue($sformatf("rr%0d", i), lat);
            case (i)
                0: cmd0 = 16'hE001;
                1: cmd1 = 16'hF001;
                2: req0 = 1'b0;
                default: req1 = 1'b0;
            endcase
            applyStimulus($sformatf("rr%0d", i), (i % 2 == 1) ? 2'b10 : 2'b01,
                          1'b0, 1'b0, 6);
        end
        checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
